// File: rtl/mips_pkg.sv
// Shared definitions for the load/store unit: memory geometry, access-size
// encodings and FSM state encoding.
package mips_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned MEM_WORDS = 64;
  localparam int unsigned IDX_W     = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MERGE_WR = 1'b1
  } lsu_state_e;

endpackage

// File: rtl/byte_lane_unit.sv
// Combinational byte-lane logic: extracts and sign/zero-extends a load lane
// from a memory word, and merges store data into the addressed lane.
// Ports:
//   i_size      access size
//   i_unsigned  zero-extend loads when set
//   i_offset    byte offset within the word (little-endian)
//   i_rdata     current memory word
//   i_wdata     right-justified store data
//   o_ld_data   extended load result
//   o_merged    memory word with the store lane replaced
module byte_lane_unit
  import mips_pkg::*;
(
  input  size_e             i_size,
  input  logic              i_unsigned,
  input  logic [1:0]        i_offset,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_ld_data,
  output logic [DATA_W-1:0] o_merged
);

  logic [4:0]        w_shamt;
  logic [DATA_W-1:0] w_lane;
  logic [DATA_W-1:0] w_mask;

  // Lane extraction and merge share one shift amount derived from the offset.
  always_comb begin
    w_shamt   = {i_offset, 3'b000};
    w_lane    = i_rdata >> w_shamt;
    o_ld_data = i_rdata;
    w_mask    = '1;
    case (i_size)
      SZ_BYTE: begin
        o_ld_data = i_unsigned ? {24'b0, w_lane[7:0]} : {{24{w_lane[7]}}, w_lane[7:0]};
        w_mask    = 32'h0000_00FF << w_shamt;
      end
      SZ_HALF: begin
        o_ld_data = i_unsigned ? {16'b0, w_lane[15:0]} : {{16{w_lane[15]}}, w_lane[15:0]};
        w_mask    = 32'h0000_FFFF << w_shamt;
      end
      SZ_WORD: begin
        o_ld_data = i_rdata;
        w_mask    = '1;
      end
      SZ_ILL: begin
        o_ld_data = i_rdata;
        w_mask    = '1;
      end
      default: begin
        o_ld_data = i_rdata;
        w_mask    = '1;
      end
    endcase
    o_merged = (i_rdata & ~w_mask) | ((i_wdata << w_shamt) & w_mask);
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit in front of a 64-word memory with combinational read data.
// Loads complete in one cycle; word stores write directly; byte/half stores
// read-merge-write over two cycles (stall asserted in the read cycle).
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   req_*                    access request (valid, write, size, unsigned, addr, wdata)
//   stall                    upstream holds request and pipeline
//   ld_valid, ld_data        registered load result
//   fault_misalign/range     registered one-cycle fault pulses
//   mem_addr/wdata/write/read, mem_rdata   memory port (word index addressing)
module load_store_unit
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall,
  output logic              ld_valid,
  output logic [DATA_W-1:0] ld_data,
  output logic              fault_misalign,
  output logic              fault_range,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata
);

  lsu_state_e        r_state;
  lsu_state_e        w_state_nxt;
  logic [DATA_W-1:0] r_merge;
  logic [IDX_W-1:0]  r_widx;
  logic              r_ld_valid;
  logic [DATA_W-1:0] r_ld_data;
  logic              r_fault_misalign;
  logic              r_fault_range;

  size_e             w_size;
  logic              w_misalign;
  logic              w_range;
  logic              w_idle_req;
  logic              w_load_ok;
  logic              w_merge_en;
  logic [DATA_W-1:0] w_ext;
  logic [DATA_W-1:0] w_merged;

  assign w_size     = size_e'(req_size);
  assign w_misalign = (w_size == SZ_ILL) ||
                      ((w_size == SZ_HALF) && req_addr[0]) ||
                      ((w_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
  assign w_range    = (req_addr >> 2) >= ADDR_W'(MEM_WORDS);
  assign w_idle_req = req_valid && (r_state == ST_IDLE);
  assign w_load_ok  = w_idle_req && !req_write && !w_misalign && !w_range;

  byte_lane_unit u_lane (
    .i_size     (w_size),
    .i_unsigned (req_unsigned),
    .i_offset   (req_addr[1:0]),
    .i_rdata    (mem_rdata),
    .i_wdata    (req_wdata),
    .o_ld_data  (w_ext),
    .o_merged   (w_merged)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next state and memory-port control.
  always_comb begin
    w_state_nxt = r_state;
    stall       = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = {2'b00, req_addr[ADDR_W-1:2]};
    mem_wdata   = req_wdata;
    w_merge_en  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid && !w_misalign && !w_range) begin
          if (!req_write) begin
            mem_read = 1'b1;
          end else if (w_size == SZ_WORD) begin
            mem_write = 1'b1;
          end else begin
            mem_read    = 1'b1;
            stall       = 1'b1;
            w_merge_en  = 1'b1;
            w_state_nxt = ST_MERGE_WR;
          end
        end
      end
      ST_MERGE_WR: begin
        mem_write   = 1'b1;
        mem_addr    = ADDR_W'(r_widx);
        mem_wdata   = r_merge;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Reset aborts any access in flight, including a pending merge write.
    if (!rst) begin
      stall     = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end
  end

  // Load result, fault pulses and merge buffer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ld_valid       <= 1'b0;
      r_ld_data        <= '0;
      r_fault_misalign <= 1'b0;
      r_fault_range    <= 1'b0;
      r_merge          <= '0;
      r_widx           <= '0;
    end else begin
      r_ld_valid       <= w_load_ok;
      r_fault_misalign <= w_idle_req && w_misalign;
      r_fault_range    <= w_idle_req && !w_misalign && w_range;
      if (w_load_ok) r_ld_data <= w_ext;
      if (w_merge_en) begin
        r_merge <= w_merged;
        r_widx  <= req_addr[IDX_W+1:2];
      end
    end
  end

  assign ld_valid       = r_ld_valid;
  assign ld_data        = r_ld_data;
  assign fault_misalign = r_fault_misalign;
  assign fault_range    = r_fault_range;

endmodule
